bram_tx_stream: RTL and testbench
=================================

# bram_tx_stream

Packet read-out stage that consumes what the frontend writes into the shared packet BRAM. On a `start` pulse carrying a byte length, it reads BRAM words 0..N-1 and emits them as a 256-bit AXI-Stream master packet with correct `tkeep`/`tlast`. It sustains one beat per cycle under backpressure. When the last beat is accepted, it pulses `finish` so the frontend can release its `axis_tready` and accept the next packet.

## Interface
- `DATA_W`, 256, stream and BRAM word width in bits.
- `ADDR_W`, 6, BRAM address width; capacity is 2^ADDR_W words (64 words, 2048 bytes).
- `aclk`  in  1  sole clock; all logic samples on its rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `length_be`  in  16  packet length in bytes, sampled together with `start`.
- `finish`  out  1  one-cycle pulse after the last beat handshake.
- `busy`  out  1  high from accepted `start` through the `finish` cycle.
- `bram_addrb`  out  ADDR_W  BRAM read address.
- `bram_enb`  out  1  read enable.
- `bram_doutb`  in  DATA_W  read data, valid exactly 1 cycle after `bram_enb`.
- `m_axis_tdata`  out  DATA_W  byte 0 is on [7:0].
- `m_axis_tkeep`  out  DATA_W/8  bit i qualifies byte i.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  marks the final beat.
- `m_axis_tready`  in  1  downstream accept.

## Operation
- Reset values: `finish`=0, `busy`=0, `bram_enb`=0, `bram_addrb`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tkeep`=0, `m_axis_tdata`=0. Reset also clears the FSM, counters, and skid buffer.
- Length rules:
  - len_eff = min(`length_be`, 2048).
  - beats = ceil(len_eff/32), held in 7 bits.
  - rem = len_eff[4:0].
  - Last-beat `tkeep` = all ones if rem==0, else (1<<rem)-1. All other beats carry all-ones `tkeep`.
- FSM states:
  - IDLE: if `start` and len_eff==0, go to DONE. If `start` and len_eff>0, latch beats and keep, go to READ. `start` in any other state is ignored.
  - READ: issue read `bram_addrb`=rd_cnt with `bram_enb`=1 whenever rd_cnt<beats and credit>0. Credit = skid free slots minus reads in flight; it never goes negative. Go to DRAIN when rd_cnt reaches beats.
  - DRAIN: wait until every beat has handshaked (tvalid&&tready with wr_cnt==beats-1), then go to DONE.
  - DONE: `finish`=1 for one cycle, `busy` drops in the same cycle, next state IDLE.
- Data path:
  - Returned BRAM words enter a 2-entry skid buffer; the buffer drives the `m_axis_*` outputs.
  - `tlast` and the trimmed `tkeep` are attached when the word index equals beats-1.
- AXIS rules:
  - Once `tvalid` is high, `tdata`/`tkeep`/`tlast` hold stable until the handshake.
  - `tvalid` never drops without a handshake.
- Reset mid-packet: outputs return to reset values on the next edge. The packet is abandoned and no `finish` is generated.

## Timing
- `start` accepted at cycle 0; first `bram_enb` at cycle 1; first `tvalid` at cycle 2.
- With `tready` held high: one beat per cycle, so the last beat is at cycle beats+1 and `finish` at cycle beats+2.
- A 1514-byte packet is 48 beats; last-beat `tkeep`=0x3FF (rem=10); `finish` at cycle 50.
- Backpressure: at most 2 words buffered plus 0 in flight. A read is never issued without a guaranteed slot, and no beat is dropped or duplicated.
- `tready` deasserted for k cycles mid-packet delays `finish` by exactly k cycles.
- `busy` covers cycles 0..beats+2 inclusive; a `start` at cycle beats+3 is accepted.

## Structure
- Shared package `tx_pkg`:
  - state encoding (one-hot, 4 states);
  - `MAX_BYTES`=2048, `BEAT_BYTES`=32;
  - a function mapping rem to last-beat `tkeep`.
- Sub-module `axis_skid2`: a 2-entry valid/ready skid buffer carrying data, keep and last, with a `free_slots` output for credit tracking.
- Top level holds the FSM, the rd_cnt and wr_cnt counters, the in-flight tracking register, and the length decode.

## Test plan
- `length_be`=1514, `tready`=1 -> 48 beats from BRAM words 0..47 in order; last beat `tkeep`=0x3FF with `tlast`; `finish` pulses at cycle 50.
- `length_be`=64 -> 2 beats, both `tkeep`=0xFFFFFFFF, `tlast` on beat 2; `length_be`=1 -> 1 beat with `tkeep`=0x1 and `tlast`.
- `length_be`=5000 -> clamped to 64 beats reading addresses 0..63, last `tkeep` all ones; `length_be`=0 -> no `tvalid`, `finish` at cycle 1.
- 1514 bytes with pseudo-random `tready` (50% duty, seeded) -> data matches the BRAM model byte for byte, `tdata` is stable while stalled, and `finish` arrives at 50 + stall cycles.
- `areset` asserted at beat 20 of 48 -> all outputs zero on the next edge and no `finish`; a subsequent 64-byte `start` completes normally.
- `start` pulsed while `busy` -> ignored; the current packet completes unchanged with a single `finish`.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the BRAM-to-AXI-Stream packet read-out path.
package tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  localparam int MAX_BYTES  = 2048;
  localparam int BEAT_BYTES = 32;
  localparam int KEEP_W     = BEAT_BYTES;

  // A zero remainder means the final beat is completely full.
  function automatic logic [KEEP_W-1:0] last_keep(input logic [4:0] rem);
    logic [KEEP_W-1:0] keep;
    if (rem == 5'd0) begin
      keep = {KEEP_W{1'b1}};
    end else begin
      keep = (KEEP_W'(1) << rem) - KEEP_W'(1);
    end
    return keep;
  endfunction

endpackage

// File: rtl/bram_tx_stream_if.sv
// AXI-Stream beat bundle; master drives data/keep/last/valid, slave drives ready.
interface bram_tx_stream_if #(parameter int DATA_W = 256);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_skid2.sv
// Two-entry fall-through skid buffer: an empty buffer forwards the in-flight BRAM word directly.
module axis_skid2
  import tx_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic [1:0]        free_slots,
  bram_tx_stream_if.master  m_axis
);

  logic [DATA_W-1:0] data_r [2];
  logic [KEEP_W-1:0] keep_r [2];
  logic              last_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;
  logic              hs_s;
  logic              push_s;
  logic              pop_s;

  // Output selection and push/pop decode
  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = {DATA_W{1'b0}};
    m_axis.tkeep  = {KEEP_W{1'b0}};
    m_axis.tlast  = 1'b0;
    if (count_r != 2'd0) begin
      m_axis.tvalid = 1'b1;
      m_axis.tdata  = data_r[rd_ptr_r];
      m_axis.tkeep  = keep_r[rd_ptr_r];
      m_axis.tlast  = last_r[rd_ptr_r];
    end else if (in_valid) begin
      m_axis.tvalid = 1'b1;
      m_axis.tdata  = in_data;
      m_axis.tkeep  = in_keep;
      m_axis.tlast  = in_last;
    end else begin
      m_axis.tvalid = 1'b0;
    end
    hs_s       = m_axis.tvalid && m_axis.tready;
    pop_s      = (count_r != 2'd0) && hs_s;
    push_s     = in_valid && !((count_r == 2'd0) && hs_s);
    free_slots = 2'd2 - count_r;
  end

  // Storage, pointers and occupancy
  always_ff @(posedge aclk) begin
    if (areset) begin
      count_r   <= 2'd0;
      rd_ptr_r  <= 1'b0;
      wr_ptr_r  <= 1'b0;
      data_r[0] <= {DATA_W{1'b0}};
      data_r[1] <= {DATA_W{1'b0}};
      keep_r[0] <= {KEEP_W{1'b0}};
      keep_r[1] <= {KEEP_W{1'b0}};
      last_r[0] <= 1'b0;
      last_r[1] <= 1'b0;
    end else begin
      if (push_s) begin
        data_r[wr_ptr_r] <= in_data;
        keep_r[wr_ptr_r] <= in_keep;
        last_r[wr_ptr_r] <= in_last;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: rtl/bram_tx_stream.sv
// Packet read-out: streams BRAM words 0..beats-1 as an AXI-Stream packet, then pulses finish.
module bram_tx_stream
  import tx_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [15:0]       length_be,
  output logic              finish,
  output logic              busy,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_enb,
  input  logic [DATA_W-1:0] bram_doutb,
  bram_tx_stream_if.master  m_axis
);

  localparam int CNT_W = ADDR_W + 1;

  state_e            state_r;
  state_e            state_next_s;
  logic [15:0]       len_eff_s;
  logic [CNT_W-1:0]  beats_s;
  logic [CNT_W-1:0]  beats_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic [CNT_W-1:0]  inflight_idx_r;
  logic [KEEP_W-1:0] keep_last_r;
  logic [KEEP_W-1:0] in_keep_s;
  logic              inflight_r;
  logic              in_last_s;
  logic              issue_s;
  logic              hs_s;
  logic              last_hs_s;
  logic [1:0]        free_slots_s;

  // Length clamp and beat count
  always_comb begin
    if (length_be > 16'(MAX_BYTES)) begin
      len_eff_s = 16'(MAX_BYTES);
    end else begin
      len_eff_s = length_be;
    end
    beats_s = CNT_W'((len_eff_s + 16'(BEAT_BYTES - 1)) / 16'(BEAT_BYTES));
  end

  // Reads are issued only when a skid slot is guaranteed for the returning word
  always_comb begin
    issue_s    = (state_r == ST_READ) && (rd_cnt_r < beats_r) &&
                 (free_slots_s > {1'b0, inflight_r});
    hs_s       = m_axis.tvalid && m_axis.tready;
    last_hs_s  = hs_s && (wr_cnt_r == beats_r - CNT_W'(1));
    in_last_s  = (inflight_idx_r == beats_r - CNT_W'(1));
    in_keep_s  = in_last_s ? keep_last_r : {KEEP_W{1'b1}};
    bram_enb   = issue_s;
    bram_addrb = rd_cnt_r[ADDR_W-1:0];
    finish     = (state_r == ST_DONE);
    busy       = (state_r != ST_IDLE) || (start && !areset);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (beats_s == CNT_W'(0)) ? ST_DONE : ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s && (rd_cnt_r == beats_r - CNT_W'(1))) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (last_hs_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, counters and in-flight tracking
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r        <= ST_IDLE;
      beats_r        <= CNT_W'(0);
      keep_last_r    <= {KEEP_W{1'b0}};
      rd_cnt_r       <= CNT_W'(0);
      wr_cnt_r       <= CNT_W'(0);
      inflight_r     <= 1'b0;
      inflight_idx_r <= CNT_W'(0);
    end else begin
      state_r        <= state_next_s;
      inflight_r     <= issue_s;
      inflight_idx_r <= rd_cnt_r;
      if ((state_r == ST_IDLE) && start) begin
        beats_r     <= beats_s;
        keep_last_r <= last_keep(len_eff_s[4:0]);
        rd_cnt_r    <= CNT_W'(0);
        wr_cnt_r    <= CNT_W'(0);
      end else begin
        if (issue_s) begin
          rd_cnt_r <= rd_cnt_r + CNT_W'(1);
        end
        if (hs_s) begin
          wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  axis_skid2 #(.DATA_W(DATA_W)) u_skid (
    .aclk       (aclk),
    .areset     (areset),
    .in_valid   (inflight_r),
    .in_data    (bram_doutb),
    .in_keep    (in_keep_s),
    .in_last    (in_last_s),
    .free_slots (free_slots_s),
    .m_axis     (m_axis)
  );

endmodule

// File: tb/tb_bram_tx_stream.sv
// Directed bench for bram_tx_stream with a BRAM model and an expected-beat scoreboard.
module tb_bram_tx_stream;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  logic         aclk;
  logic         areset;
  logic         start;
  logic [15:0]  length_be;
  logic         finish;
  logic         busy;
  logic [5:0]   bram_addrb;
  logic         bram_enb;
  logic [255:0] bram_doutb;
  logic [255:0] mem [64];
  beat_t        sb [$];
  int           n_asserts = 0;
  int           n_fails   = 0;

  bram_tx_stream_if #(.DATA_W(256)) m_axis ();

  bram_tx_stream #(.DATA_W(256), .ADDR_W(6)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .length_be  (length_be),
    .finish     (finish),
    .busy       (busy),
    .bram_addrb (bram_addrb),
    .bram_enb   (bram_enb),
    .bram_doutb (bram_doutb),
    .m_axis     (m_axis)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // One-cycle-latency BRAM read port
  always @(posedge aclk) begin
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_keep(input int rem);
    logic [31:0] k;
    k = 32'hFFFF_FFFF;
    if (rem != 0) begin
      k = 32'h0;
      for (int i = 0; i < rem; i++) k[i] = 1'b1;
    end
    return k;
  endfunction

  // Runs one packet; rnd selects random tready, inj_cyc (>0) injects a start while busy.
  task automatic run_pkt(input int len, input bit rnd, input int inj_cyc);
    int           eff, beats, stall, rd_exp, first_v, cyc;
    bit           done, prev_stall;
    logic [255:0] prev_data;
    beat_t        e;
    logic [31:0]  lk;
    eff   = (len > 2048) ? 2048 : len;
    beats = (eff + 31) / 32;
    lk    = exp_keep(eff % 32);
    for (int i = 0; i < beats; i++) begin
      e.data = mem[i];
      e.last = (i == beats - 1);
      e.keep = e.last ? lk : 32'hFFFF_FFFF;
      sb.push_back(e);
    end
    @(negedge aclk);
    start         = 1'b1;
    length_be     = 16'(len);
    m_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check("busy_at_start", {255'd0, busy}, 256'd1);
    stall = 0; rd_exp = 0; first_v = -1; done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (cyc = 1; cyc < 400 && !done; cyc++) begin
      @(negedge aclk);
      start         = (cyc == inj_cyc);
      length_be     = (cyc == inj_cyc) ? 16'd64 : 16'(len);
      m_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) begin
        check("hold_tvalid", {255'd0, m_axis.tvalid}, 256'd1);
        check("hold_tdata", m_axis.tdata, prev_data);
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      if (bram_enb) begin
        check("rd_addr", 256'(bram_addrb), 256'(rd_exp));
        rd_exp++;
      end
      if (m_axis.tvalid) begin
        if (first_v < 0) first_v = cyc;
        if (m_axis.tready) begin
          if (sb.size() == 0) begin
            check("extra_beat", 256'd1, 256'd0);
          end else begin
            e = sb.pop_front();
            check("tdata", m_axis.tdata, e.data);
            check("tkeep", 256'(m_axis.tkeep), 256'(e.keep));
            check("tlast", {255'd0, m_axis.tlast}, {255'd0, e.last});
          end
        end else begin
          stall++;
        end
      end
      if (finish) begin
        check("finish_cycle", 256'(cyc), 256'((beats == 0) ? 1 : beats + 2 + stall));
        check("beats_left", 256'(sb.size()), 256'd0);
        check("read_count", 256'(rd_exp), 256'(beats));
        check("busy_in_finish", {255'd0, busy}, 256'd1);
        done = 1'b1;
      end
    end
    start = 1'b0;
    if (!done) check("finish_timeout", 256'd0, 256'd1);
    if (!rnd && beats > 0) check("first_tvalid_cycle", 256'(first_v), 256'd2);
    if (beats == 0) check("no_tvalid", 256'(first_v + 1), 256'd0);
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      m_axis.tready = 1'b1;
      #1;
      check("post_finish", {255'd0, finish}, 256'd0);
      check("post_busy", {255'd0, busy}, 256'd0);
      check("post_tvalid", {255'd0, m_axis.tvalid}, 256'd0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, {255'd0, m_axis.tvalid}, 256'd0);
    check({tag, "_tlast"}, {255'd0, m_axis.tlast}, 256'd0);
    check({tag, "_tkeep"}, 256'(m_axis.tkeep), 256'd0);
    check({tag, "_tdata"}, m_axis.tdata, 256'd0);
    check({tag, "_enb"}, {255'd0, bram_enb}, 256'd0);
    check({tag, "_addr"}, 256'(bram_addrb), 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_finish"}, {255'd0, finish}, 256'd0);
  endtask

  initial begin
    int hs_cnt, fin_cnt;
    for (int a = 0; a < 64; a++)
      for (int j = 0; j < 8; j++) mem[a][32*j +: 32] = $urandom;
    bram_doutb    = '0;
    areset        = 1'b1;
    start         = 1'b0;
    length_be     = 16'd0;
    m_axis.tready = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_outputs_zero("reset");
    @(negedge aclk);
    areset = 1'b0;

    run_pkt(1514, 1'b0, -1);
    run_pkt(64, 1'b0, -1);
    run_pkt(1, 1'b0, -1);
    run_pkt(5000, 1'b0, -1);
    run_pkt(0, 1'b0, -1);
    void'($urandom(32'd2024));
    run_pkt(1514, 1'b1, -1);

    // Abandon a 1514-byte packet after 20 accepted beats.
    @(negedge aclk);
    start = 1'b1; length_be = 16'd1514; m_axis.tready = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 100 && hs_cnt < 20; c++) begin
      @(negedge aclk);
      start = 1'b0;
      #1;
      if (m_axis.tvalid && m_axis.tready) hs_cnt++;
    end
    check("beats_before_reset", 256'(hs_cnt), 256'd20);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    fin_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge aclk);
      #1;
      if (finish) fin_cnt++;
    end
    check("no_finish_after_abort", 256'(fin_cnt), 256'd0);
    run_pkt(64, 1'b0, -1);

    run_pkt(1514, 1'b0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
